hyp_rot_cordic_seq: RTL and testbench

- Iterative hyperbolic-rotation CORDIC: takes angle z in Q8.24 and drives it to 0 by micro-rotations, producing cosh(z), sinh(z) and exp(z) = cosh + sinh.
- It is the rotation-mode counterpart of the existing hyperbolic vectoring unit, which computes atanh/ln. Together they form the exponent datapath.
- One micro-rotation per clock. Valid/ready on both sides. Range reduction happens upstream.

---
 rtl/hyp_cordic_pkg.sv | 30 +++
 rtl/hyp_atanh_rom.sv | 28 ++
 rtl/hyp_rot_cordic_seq.sv | 112 +++++++++++
 tb/tb_hyp_rot_cordic_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hyp_cordic_pkg.sv
// Shared constants and types for the hyperbolic CORDIC exponent datapath.
// Q8.24 fixed point, two's complement.
package hyp_cordic_pkg;

    localparam int W    = 32;
    localparam int FRAC = 24;
    localparam int ITER = 24;

    // 1/K_h for shifts 1..24 with 4 and 13 taken twice
    localparam logic [W-1:0] KINV = 32'h0135_1E87;
    localparam logic [W-1:0] ZMAX = 32'h011E_0000;
    localparam logic [W-1:0] ONE  = W'(1) << FRAC;

    localparam logic [4:0] REP_IDX_A = 5'd4;
    localparam logic [4:0] REP_IDX_B = 5'd13;
    localparam logic [4:0] LAST_IDX  = 5'(ITER);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    function automatic logic out_of_range(input logic [W-1:0] z);
        logic [W-1:0] mag;
        mag = z[W-1] ? (~z + 1'b1) : z;
        return (z == {1'b1, {(W-1){1'b0}}}) || (mag > ZMAX);
    endfunction

endpackage

// File: rtl/hyp_atanh_rom.sv
// atanh(2^-i) table in Q8.24, rounded to nearest.
// Beyond i=8 the value equals 2^-i to within half an LSB.
module hyp_atanh_rom
    import hyp_cordic_pkg::*;
(
    input  logic [4:0]   idx,
    output logic [W-1:0] atanh
);

    always_comb begin
        atanh = '0;
        case (idx)
            5'd1: atanh = 32'h008C_9F54;
            5'd2: atanh = 32'h0041_62BC;
            5'd3: atanh = 32'h0020_2B12;
            5'd4: atanh = 32'h0010_0559;
            5'd5: atanh = 32'h0008_00AB;
            5'd6: atanh = 32'h0004_0015;
            5'd7: atanh = 32'h0002_0003;
            5'd8: atanh = 32'h0001_0000;
            default: begin
                if (idx >= 5'd9 && idx <= LAST_IDX)
                    atanh = ONE >> idx;
            end
        endcase
    end

endmodule

// File: rtl/hyp_rot_cordic_seq.sv
// Iterative hyperbolic-rotation CORDIC: z -> cosh, sinh, exp.
// One micro-rotation per clock, valid/ready on both sides.
module hyp_rot_cordic_seq
    import hyp_cordic_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] cosh_out,
    output logic [W-1:0] sinh_out,
    output logic [W-1:0] exp_out,
    output logic         rng_err
);

    state_t state, state_nx;

    logic                live;
    logic signed [W-1:0] x, y, z;
    logic [4:0]          idx;
    logic                rep;
    logic                rng_err_r;

    logic [W-1:0]        atanh_i;
    logic signed [W-1:0] x_sh, y_sh;
    logic signed [W-1:0] x_nx, y_nx, z_nx;
    logic                dir, hold, last, accept;

    hyp_atanh_rom u_rom (
        .idx   (idx),
        .atanh (atanh_i)
    );

    assign in_ready  = live && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // first visit to a repeat index holds it for one more rotation
    assign hold = !rep && (idx == REP_IDX_A || idx == REP_IDX_B);
    assign last = (idx == LAST_IDX);

    assign dir  = ~z[W-1];
    assign x_sh = x >>> idx;
    assign y_sh = y >>> idx;
    assign x_nx = dir ? (x + y_sh) : (x - y_sh);
    assign y_nx = dir ? (y + x_sh) : (y - x_sh);
    assign z_nx = dir ? (z - signed'(atanh_i))
                      : (z + signed'(atanh_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = ROT;
            ROT:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // ready only rises on the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            idx       <= '0;
            rep       <= 1'b0;
            rng_err_r <= 1'b0;
            cosh_out  <= '0;
            sinh_out  <= '0;
            exp_out   <= '0;
            rng_err   <= 1'b0;
        end else if (accept) begin
            x         <= KINV;
            y         <= '0;
            z         <= z_in;
            idx       <= 5'd1;
            rep       <= 1'b0;
            rng_err_r <= out_of_range(z_in);
        end else if (state == ROT) begin
            x <= x_nx;
            y <= y_nx;
            z <= z_nx;
            if (hold) begin
                rep <= 1'b1;
            end else begin
                rep <= 1'b0;
                idx <= idx + 5'd1;
            end
            if (last) begin
                cosh_out <= x_nx;
                sinh_out <= y_nx;
                exp_out  <= x_nx + y_nx;
                rng_err  <= rng_err_r;
            end
        end
    end

endmodule

// File: tb/tb_hyp_rot_cordic_seq.sv
// Scoreboard bench for hyp_rot_cordic_seq: directed angles with
// expected cosh/sinh/exp values in Q8.24 (rounded true values).
module tb_hyp_rot_cordic_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] z_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] cosh_out;
    logic [31:0] sinh_out;
    logic [31:0] exp_out;
    logic        rng_err;

    localparam int TOL = 64;

    typedef struct {
        bit chk;
        int c;
        int s;
        int e;
        bit rng;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hyp_rot_cordic_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cosh_out  (cosh_out),
        .sinh_out  (sinh_out),
        .exp_out   (exp_out),
        .rng_err   (rng_err)
    );

    task automatic check(input string name, input int act,
                         input int req, input int tol);
        int d;
        d = act - req;
        if (d < 0) d = -d;
        n_vec++;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)",
                     name, act, req, tol);
        end
    endtask

    // monitor: compare on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0, 0);
            end else begin
                e = sb.pop_front();
                check("rng_err", int'(rng_err), int'(e.rng), 0);
                if (e.chk) begin
                    check("cosh", int'(cosh_out), e.c, TOL);
                    check("sinh", int'(sinh_out), e.s, TOL);
                    check("exp", int'(exp_out), e.e, TOL);
                end
            end
        end
    end

    // call away from a posedge; returns #1 after the edge
    // at which out_valid was first seen high
    task automatic send(input logic [31:0] z, input bit chk,
                        input int c, input int s, input int e,
                        input bit rng, output int wt);
        exp_t x;
        int   lat;
        x.chk = chk;
        x.c   = c;
        x.s   = s;
        x.e   = e;
        x.rng = rng;
        sb.push_back(x);
        in_valid = 1'b1;
        z_in     = z;
        wt = 0;
        while (!in_ready && wt < 100) begin
            @(posedge clk);
            #2;
            wt++;
        end
        check("accept", int'(in_ready), 1, 0);
        if (!in_ready) begin
            void'(sb.pop_back());
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 26, 0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wt;
        #1;
        check("rst_in_ready", int'(in_ready), 0, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", int'(in_ready), 1, 0);
        check("rel_out_valid", int'(out_valid), 0, 0);
        check("rel_cosh", int'(cosh_out), 0, 0);
        check("rel_sinh", int'(sinh_out), 0, 0);
        check("rel_exp", int'(exp_out), 0, 0);
        check("rel_rng", int'(rng_err), 0, 0);
        #1;

        // z = 0, 0.5, -1.0
        send(32'h0000_0000, 1'b1, 16777216, 0,
             16777216, 1'b0, wt);
        drain();
        send(32'h0080_0000, 1'b1, 18918424, 8742528,
             27660953, 1'b0, wt);
        drain();
        send(32'hFF00_0000, 1'b1, 25888597, -19716604,
             6171993, 1'b0, wt);
        drain();

        // backpressure: hold results 10 cycles at z = 0.25
        out_ready = 1'b0;
        send(32'h0040_0000, 1'b1, 17304240, 4238131,
             21542372, 1'b0, wt);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", int'(out_valid), 1, 0);
            check("hold_in_ready", int'(in_ready), 0, 0);
            check("hold_cosh", int'(cosh_out), 17304240, TOL);
            check("hold_sinh", int'(sinh_out), 4238131, TOL);
            check("hold_exp", int'(exp_out), 21542372, TOL);
        end
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pop_in_ready", int'(in_ready), 1, 0);
        check("pop_out_valid", int'(out_valid), 0, 0);
        #1;
        send(32'h0000_0000, 1'b1, 16777216, 0,
             16777216, 1'b0, wt);
        check("b2b_wait", wt, 0, 0);
        drain();

        // range flag boundaries
        send(32'h0180_0000, 1'b0, 0, 0, 0, 1'b1, wt);
        drain();
        send(32'h0000_0000, 1'b1, 16777216, 0,
             16777216, 1'b0, wt);
        drain();
        send(32'h8000_0000, 1'b0, 0, 0, 0, 1'b1, wt);
        drain();
        send(32'h011E_0001, 1'b0, 0, 0, 0, 1'b1, wt);
        drain();
        send(32'h011E_0000, 1'b0, 0, 0, 0, 1'b0, wt);
        drain();
        send(32'hFEE2_0000, 1'b0, 0, 0, 0, 1'b0, wt);
        drain();

        // reset in the middle of a rotation sequence
        in_valid = 1'b1;
        z_in     = 32'h0080_0000;
        check("mid_pre_ready", int'(in_ready), 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", int'(out_valid), 0, 0);
        check("mid_in_ready", int'(in_ready), 0, 0);
        check("mid_cosh", int'(cosh_out), 0, 0);
        check("mid_sinh", int'(sinh_out), 0, 0);
        check("mid_exp", int'(exp_out), 0, 0);
        check("mid_rng", int'(rng_err), 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", int'(in_ready), 1, 0);
        check("mid_rel_valid", int'(out_valid), 0, 0);
        #1;
        send(32'h0080_0000, 1'b1, 18918424, 8742528,
             27660953, 1'b0, wt);
        drain();

        repeat (5) @(posedge clk);
        check("sb_empty", sb.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
